// File: rtl/p4_router_ingress_arbiter.sv
// -----------------------------------------------------------------------------
// p4_router_ingress_arbiter
//
// Packet-granular round-robin arbiter that merges NUM_PORTS ingress AXI-Stream
// sources onto the single P4 pipeline input stream. A grant is taken in IDLE
// (one bubble cycle per packet) and held for the whole packet, so the arbiter
// never re-arbitrates mid-packet. Packets longer than MAX_PKT_BEATS are cut:
// the last forwarded beat carries a forced tlast and the rest of the source
// packet is drained and discarded.
//
// Optional build macro: P4_ROUTER_INGRESS_ARB_PKT_CNT_EN
//   When defined, adds pkt_cnt: one 32-bit wrapping packet counter per port,
//   counting source packet completions (including truncated packets).
//
// Ports:
//   clk                     single clock
//   sreset                  synchronous active-high reset
//   port_en[N]              per-port grant enable (sampled at arbitration only)
//   in_tdata/tkeep/tlast/tvalid  packed sources, port i in slice i
//   in_tready[N]            per-source ready (only the granted port may be 1)
//   out_tdata/tkeep/tlast/tvalid, out_tready   stream to the pipeline
//   user_metadata_out       {zeros, 8'h00, ingress id[7:0]}, registered at grant
//   user_metadata_out_valid out_tvalid on the first beat of each packet
//   truncate_event          one-cycle pulse after a truncated beat
//   pkt_cnt[N*32]           (optional) per-port packet counters
// -----------------------------------------------------------------------------
module p4_router_ingress_arbiter #(
  parameter int NUM_PORTS           = 11,
  parameter int DATA_BYTES          = 8,
  parameter int USER_METADATA_WIDTH = 16,
  parameter int MAX_PKT_BEATS       = 1024
) (
  input  logic                              clk,
  input  logic                              sreset,
  input  logic [NUM_PORTS-1:0]              port_en,
  input  logic [NUM_PORTS*DATA_BYTES*8-1:0] in_tdata,
  input  logic [NUM_PORTS*DATA_BYTES-1:0]   in_tkeep,
  input  logic [NUM_PORTS-1:0]              in_tlast,
  input  logic [NUM_PORTS-1:0]              in_tvalid,
  output logic [NUM_PORTS-1:0]              in_tready,
  output logic [DATA_BYTES*8-1:0]           out_tdata,
  output logic [DATA_BYTES-1:0]             out_tkeep,
  output logic                              out_tlast,
  output logic                              out_tvalid,
  input  logic                              out_tready,
  output logic [USER_METADATA_WIDTH-1:0]    user_metadata_out,
  output logic                              user_metadata_out_valid,
  output logic                              truncate_event
`ifdef P4_ROUTER_INGRESS_ARB_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*32-1:0]           pkt_cnt
`endif
);

  localparam int DW     = DATA_BYTES * 8;
  localparam int PTR_W  = $clog2(NUM_PORTS);
  localparam int BEAT_W = $clog2(MAX_PKT_BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                         state_q;
  logic [PTR_W-1:0]               rr_ptr_q;
  logic [PTR_W-1:0]               rr_ptr_d;
  logic [PTR_W-1:0]               grant_q;
  logic [BEAT_W-1:0]              beat_cnt_q;
  logic                           first_beat_q;
  logic                           trunc_q;
  logic [USER_METADATA_WIDTH-1:0] meta_q;

  // Unpacked views of the packed source buses.
  logic [DW-1:0]         tdata_arr [NUM_PORTS];
  logic [DATA_BYTES-1:0] tkeep_arr [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign tdata_arr[gi] = in_tdata[gi*DW +: DW];
    assign tkeep_arr[gi] = in_tkeep[gi*DATA_BYTES +: DATA_BYTES];
  end

  // Granted-source selection.
  logic          sel_valid;
  logic          sel_last;
  logic [DW-1:0] sel_data;
  logic [DATA_BYTES-1:0] sel_keep;

  assign sel_valid = in_tvalid[grant_q];
  assign sel_last  = in_tlast[grant_q];
  assign sel_data  = tdata_arr[grant_q];
  assign sel_keep  = tkeep_arr[grant_q];

  // Round-robin search: first requesting port at or above rr_ptr, with wrap.
  logic [NUM_PORTS-1:0] req;
  logic                 arb_found;
  logic [PTR_W-1:0]     arb_idx;
  logic [PTR_W:0]       cand;

  always_comb begin
    req       = in_tvalid & port_en;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_PORTS)) begin
        cand = cand - (PTR_W+1)'(NUM_PORTS);
      end
      if (!arb_found && req[cand[PTR_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Next pointer after a packet from grant_q completes.
  assign rr_ptr_d = (grant_q == PTR_W'(NUM_PORTS-1)) ? '0 : grant_q + PTR_W'(1);

  logic trunc_beat;
  logic pass_hs;
  logic src_done;

  assign trunc_beat = (beat_cnt_q == BEAT_W'(MAX_PKT_BEATS-1));
  assign pass_hs    = (state_q == PASS) && sel_valid && out_tready;
  // Source-side packet completion: last beat accepted while forwarding or draining.
  assign src_done   = (pass_hs && sel_last) ||
                      ((state_q == DROP) && sel_valid && sel_last);

  // Zero-latency pass-through of the granted source; everything else is 0.
  always_comb begin
    in_tready  = '0;
    out_tdata  = '0;
    out_tkeep  = '0;
    out_tlast  = 1'b0;
    out_tvalid = 1'b0;
    case (state_q)
      PASS: begin
        out_tdata          = sel_data;
        out_tkeep          = sel_keep;
        out_tvalid         = sel_valid;
        // A runaway packet gets a forced tlast on its final permitted beat.
        out_tlast          = sel_last | trunc_beat;
        in_tready[grant_q] = out_tready;
      end
      DROP: begin
        in_tready[grant_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign user_metadata_out       = meta_q;
  assign user_metadata_out_valid = out_tvalid & first_beat_q;
  assign truncate_event          = trunc_q;

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      beat_cnt_q   <= '0;
      first_beat_q <= 1'b0;
      trunc_q      <= 1'b0;
      meta_q       <= '0;
    end else begin
      trunc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_found) begin
            grant_q      <= arb_idx;
            meta_q       <= USER_METADATA_WIDTH'(arb_idx);
            first_beat_q <= 1'b1;
            beat_cnt_q   <= '0;
            state_q      <= PASS;
          end
        end
        PASS: begin
          if (pass_hs) begin
            first_beat_q <= 1'b0;
            if (sel_last) begin
              beat_cnt_q <= '0;
              rr_ptr_q   <= rr_ptr_d;
              state_q    <= IDLE;
            end else if (trunc_beat) begin
              beat_cnt_q <= '0;
              trunc_q    <= 1'b1;
              state_q    <= DROP;
            end else begin
              beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            end
          end
        end
        DROP: begin
          if (sel_valid && sel_last) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef P4_ROUTER_INGRESS_ARB_PKT_CNT_EN
  logic [31:0] pkt_cnt_q [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_pkt_cnt
    always_ff @(posedge clk) begin
      if (sreset) begin
        pkt_cnt_q[gi] <= '0;
      end else if (src_done && (grant_q == PTR_W'(gi))) begin
        pkt_cnt_q[gi] <= pkt_cnt_q[gi] + 32'd1;
      end
    end
    assign pkt_cnt[gi*32 +: 32] = pkt_cnt_q[gi];
  end
`else
  // Completion strobe only feeds the optional counters.
  logic unused_src_done;
  assign unused_src_done = src_done;
`endif

endmodule

// File: tb/tb_p4_router_ingress_arbiter.sv
module tb_p4_router_ingress_arbiter;

  localparam int NP   = 11;
  localparam int DB   = 8;
  localparam int UMW  = 16;
  localparam int MAXB = 4;
  localparam int DW   = DB * 8;

  logic                 clk;
  logic                 sreset;
  logic [NP-1:0]        port_en;
  logic [NP*DW-1:0]     in_tdata;
  logic [NP*DB-1:0]     in_tkeep;
  logic [NP-1:0]        in_tlast;
  logic [NP-1:0]        in_tvalid;
  logic [NP-1:0]        in_tready;
  logic [DW-1:0]        out_tdata;
  logic [DB-1:0]        out_tkeep;
  logic                 out_tlast;
  logic                 out_tvalid;
  logic                 out_tready;
  logic [UMW-1:0]       user_metadata_out;
  logic                 user_metadata_out_valid;
  logic                 truncate_event;
`ifdef P4_ROUTER_INGRESS_ARB_PKT_CNT_EN
  logic [NP*32-1:0]     pkt_cnt;
`endif

  p4_router_ingress_arbiter #(
    .NUM_PORTS(NP), .DATA_BYTES(DB), .USER_METADATA_WIDTH(UMW), .MAX_PKT_BEATS(MAXB)
  ) dut (
    .clk(clk), .sreset(sreset), .port_en(port_en),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready),
    .user_metadata_out(user_metadata_out),
    .user_metadata_out_valid(user_metadata_out_valid),
    .truncate_event(truncate_event)
`ifdef P4_ROUTER_INGRESS_ARB_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [DB-1:0] keep;
    bit            first;
    bit            last;
  } beat_t;

  typedef struct {
    logic [UMW-1:0] meta;
    logic [DW-1:0]  data;
    logic [DB-1:0]  keep;
    bit             last;
    bit             mvalid;
  } obs_t;

  beat_t src_q [NP][$];
  obs_t  exp_q[$];
  obs_t  obs_q[$];
  int    hs_cyc_q[$];
  int    trunc_cyc_q[$];
  int    forced_cyc_q[$];
  int    model_rr;
  int    model_trunc;
  int    exp_cnt [NP];
  int    total;
  int    bad;
  int    cyc;
  bit    timeout;
  int    rdy_viol;
  logic [3:0] rdy_pat = 4'b1001;

  // Queue one source packet of len beats on port p.
  task automatic add_pkt(int p, int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.data  = {$urandom(), $urandom()};
      b.keep  = DB'($urandom());
      b.first = (j == 0);
      b.last  = (j == len - 1);
      src_q[p].push_back(b);
    end
  endtask

  // Packet-level reference: serve whole packets in round-robin order among
  // enabled ports with pending packets, cutting each at MAXB beats.
  function automatic void build_expected(logic [NP-1:0] en);
    beat_t tmp [NP][$];
    beat_t b;
    obs_t  e;
    int    found;
    int    j;
    bit    done;
    exp_q.delete();
    for (int p = 0; p < NP; p++) tmp[p] = src_q[p];
    while (1) begin
      found = -1;
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (model_rr + k) % NP;
        if (found < 0 && en[p] && tmp[p].size() > 0) found = p;
      end
      if (found < 0) break;
      j = 0;
      done = 0;
      while (!done) begin
        b = tmp[found].pop_front();
        if (j < MAXB) begin
          e.meta   = UMW'(found);
          e.data   = b.data;
          e.keep   = b.keep;
          e.last   = b.last || (j == MAXB - 1);
          e.mvalid = (j == 0);
          exp_q.push_back(e);
        end
        done = b.last;
        j++;
      end
      if (j > MAXB) model_trunc++;
      exp_cnt[found]++;
      model_rr = (found + 1) % NP;
    end
  endfunction

  task automatic drive_inputs(int rmode);
    beat_t b;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        b = src_q[p][0];
        in_tvalid[p] = (rmode == 2 && !b.first) ? ($urandom_range(3) != 0) : 1'b1;
        in_tdata[p*DW +: DW] = b.data;
        in_tkeep[p*DB +: DB] = b.keep;
        in_tlast[p] = b.last;
      end else begin
        in_tvalid[p] = 1'b0;
        in_tdata[p*DW +: DW] = '0;
        in_tkeep[p*DB +: DB] = '0;
        in_tlast[p] = 1'b0;
      end
    end
    case (rmode)
      0:       out_tready = 1'b1;
      1:       out_tready = rdy_pat[cyc % 4];
      default: out_tready = 1'($urandom_range(1));
    endcase
  endtask

  task automatic pop_sources();
    for (int p = 0; p < NP; p++) begin
      if (in_tvalid[p] && in_tready[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    end
  endtask

  // Plays all queued packets of enabled ports and records what comes out.
  task automatic run_traffic(logic [NP-1:0] en, int rmode);
    obs_t o;
    int   gp;
    int   pending;
    int   tail;
    logic [NP-1:0] want_rdy;
    obs_q.delete(); hs_cyc_q.delete(); trunc_cyc_q.delete(); forced_cyc_q.delete();
    timeout = 0; rdy_viol = 0; cyc = 0; tail = 0;
    build_expected(en);
    while (1) begin
      @(negedge clk);
      port_en = en;
      drive_inputs(rmode);
      #1;
      if ($countones(in_tready) > 1) rdy_viol++;
      if (out_tvalid && obs_q.size() < exp_q.size()) begin
        want_rdy = '0;
        want_rdy[exp_q[obs_q.size()].meta[3:0]] = out_tready;
        if (in_tready !== want_rdy) rdy_viol++;
      end
      if (truncate_event) trunc_cyc_q.push_back(cyc);
      if (out_tvalid && out_tready) begin
        gp = -1;
        for (int p = 0; p < NP; p++) if (in_tready[p]) gp = p;
        o.meta = user_metadata_out; o.data = out_tdata; o.keep = out_tkeep;
        o.last = out_tlast; o.mvalid = user_metadata_out_valid;
        obs_q.push_back(o);
        hs_cyc_q.push_back(cyc);
        if (gp >= 0 && out_tlast && !in_tlast[gp]) forced_cyc_q.push_back(cyc);
      end
      pop_sources();
      cyc++;
      pending = 0;
      for (int p = 0; p < NP; p++) if (en[p]) pending += src_q[p].size();
      if (pending == 0) tail++;
      if (tail >= 3) break;
      if (cyc > 2000) begin
        timeout = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sreset = 1'b1; port_en = '1; in_tvalid = '1; in_tlast = '1; out_tready = 1'b1;
    in_tdata = '1; in_tkeep = '1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (in_tready !== '0) begin bad++; $display("FAIL reset_in_tready got %h want 0", in_tready); end
    total++;
    if ({out_tvalid, out_tlast, out_tdata, out_tkeep} !== '0) begin
      bad++; $display("FAIL reset_out got v=%b l=%b d=%h k=%h want 0", out_tvalid, out_tlast, out_tdata, out_tkeep);
    end
    total++;
    if ({user_metadata_out, user_metadata_out_valid, truncate_event} !== '0) begin
      bad++; $display("FAIL reset_meta got %h/%b trunc=%b want 0", user_metadata_out, user_metadata_out_valid, truncate_event);
    end
`ifdef P4_ROUTER_INGRESS_ARB_PKT_CNT_EN
    total++;
    if (pkt_cnt !== '0) begin bad++; $display("FAIL reset_pkt_cnt got %h want 0", pkt_cnt); end
`endif
    @(negedge clk);
    in_tvalid = '0; in_tlast = '0; in_tdata = '0; in_tkeep = '0; sreset = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({out_tvalid, in_tready} !== '0) begin
      bad++; $display("FAIL reset_idle got v=%b rdy=%h want 0", out_tvalid, in_tready);
    end
    model_rr = 0;
    for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
    $display("test_reset done");
  endtask

  task automatic test_rr_order();
    add_pkt(0, 4); add_pkt(3, 4); add_pkt(10, 4);
    run_traffic('1, 0);
    total++;
    if (timeout || obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rr_order count got %0d want %0d timeout=%b", obs_q.size(), exp_q.size(), timeout);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] != exp_q[i]) begin
        bad++;
        $display("FAIL rr_order beat %0d got meta=%h l=%b mv=%b d=%h k=%h want meta=%h l=%b mv=%b d=%h k=%h", i,
                 obs_q[i].meta, obs_q[i].last, obs_q[i].mvalid, obs_q[i].data, obs_q[i].keep,
                 exp_q[i].meta, exp_q[i].last, exp_q[i].mvalid, exp_q[i].data, exp_q[i].keep);
      end
    end
    $display("test_rr_order: %0d beats", obs_q.size());
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) add_pkt(5, 2);
    add_pkt(6, 2);
    run_traffic('1, 0);
    total++;
    if (timeout || obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL b2b count got %0d want %0d timeout=%b", obs_q.size(), exp_q.size(), timeout);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] != exp_q[i]) begin
        bad++;
        $display("FAIL b2b beat %0d got meta=%h l=%b mv=%b d=%h want meta=%h l=%b mv=%b d=%h", i,
                 obs_q[i].meta, obs_q[i].last, obs_q[i].mvalid, obs_q[i].data,
                 exp_q[i].meta, exp_q[i].last, exp_q[i].mvalid, exp_q[i].data);
      end
    end
    // 8 beats plus one arbitration bubble ahead of each of the 4 packets.
    if (hs_cyc_q.size() > 0) begin
      total++;
      if (hs_cyc_q[hs_cyc_q.size()-1] != exp_q.size() + 4 - 1) begin
        bad++; $display("FAIL b2b last_cycle got %0d want %0d", hs_cyc_q[hs_cyc_q.size()-1], exp_q.size() + 3);
      end
    end
    $display("test_back_to_back: %0d beats", obs_q.size());
  endtask

  task automatic test_truncate();
    int t0;
    t0 = model_trunc;
    add_pkt(2, 7); add_pkt(2, 1);
    run_traffic('1, 0);
    total++;
    if (timeout || obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL trunc count got %0d want %0d timeout=%b", obs_q.size(), exp_q.size(), timeout);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] != exp_q[i]) begin
        bad++;
        $display("FAIL trunc beat %0d got meta=%h l=%b mv=%b d=%h want meta=%h l=%b mv=%b d=%h", i,
                 obs_q[i].meta, obs_q[i].last, obs_q[i].mvalid, obs_q[i].data,
                 exp_q[i].meta, exp_q[i].last, exp_q[i].mvalid, exp_q[i].data);
      end
    end
    total++;
    if (trunc_cyc_q.size() != model_trunc - t0) begin
      bad++; $display("FAIL trunc pulses got %0d want %0d", trunc_cyc_q.size(), model_trunc - t0);
    end
    total++;
    if (forced_cyc_q.size() != model_trunc - t0) begin
      bad++; $display("FAIL trunc forced_last got %0d want %0d", forced_cyc_q.size(), model_trunc - t0);
    end
    if (trunc_cyc_q.size() > 0 && forced_cyc_q.size() > 0) begin
      total++;
      if (trunc_cyc_q[0] != forced_cyc_q[0] + 1) begin
        bad++; $display("FAIL trunc pulse_cycle got %0d want %0d", trunc_cyc_q[0], forced_cyc_q[0] + 1);
      end
    end
    $display("test_truncate: %0d beats, %0d pulses", obs_q.size(), trunc_cyc_q.size());
  endtask

  task automatic test_backpressure();
    add_pkt(1, 3);
    run_traffic('1, 1);
    total++;
    if (timeout || obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL bp count got %0d want %0d timeout=%b", obs_q.size(), exp_q.size(), timeout);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] != exp_q[i]) begin
        bad++;
        $display("FAIL bp beat %0d got d=%h k=%h l=%b want d=%h k=%h l=%b", i,
                 obs_q[i].data, obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
    total++;
    if (rdy_viol != 0) begin bad++; $display("FAIL bp in_tready got %0d bad cycles want 0", rdy_viol); end
    $display("test_backpressure: %0d beats", obs_q.size());
  endtask

  task automatic test_port_en();
    logic [NP-1:0] en;
    int wait_cyc;
    en = '1; en[4] = 1'b0;
    add_pkt(4, 2); add_pkt(7, 2);
    run_traffic(en, 0);
    total++;
    if (timeout || obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL port_en count got %0d want %0d timeout=%b", obs_q.size(), exp_q.size(), timeout);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].meta !== exp_q[i].meta || obs_q[i].data !== exp_q[i].data) begin
        bad++; $display("FAIL port_en beat %0d got meta=%h d=%h want meta=%h d=%h", i,
                        obs_q[i].meta, obs_q[i].data, exp_q[i].meta, exp_q[i].data);
      end
    end
    total++;
    if (src_q[4].size() != 2) begin bad++; $display("FAIL port_en disabled_consumed got %0d want 2", src_q[4].size()); end
    // Re-enable port 4 with the pipeline stalled and time the grant.
    wait_cyc = 0;
    while (1) begin
      @(negedge clk);
      port_en = '1; drive_inputs(0); out_tready = 1'b0;
      #1;
      wait_cyc++;
      if ((out_tvalid && user_metadata_out == UMW'(4)) || wait_cyc >= 10) break;
    end
    total++;
    if (wait_cyc > 2) begin bad++; $display("FAIL port_en regrant got %0d cycles want <=2", wait_cyc); end
    run_traffic('1, 0);
    total++;
    if (timeout || obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL port_en drain got %0d want %0d timeout=%b", obs_q.size(), exp_q.size(), timeout);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] != exp_q[i]) begin
        bad++; $display("FAIL port_en drain beat %0d got meta=%h mv=%b d=%h want meta=%h mv=%b d=%h", i,
                        obs_q[i].meta, obs_q[i].mvalid, obs_q[i].data, exp_q[i].meta, exp_q[i].mvalid, exp_q[i].data);
      end
    end
    $display("test_port_en: regrant after %0d cycles", wait_cyc);
  endtask

  task automatic test_random();
    int t0;
    for (int it = 0; it < 4; it++) begin
      t0 = model_trunc;
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(2) != 0) add_pkt(p, $urandom_range(1, 6));
        if ($urandom_range(3) == 0) add_pkt(p, $urandom_range(1, 6));
      end
      run_traffic('1, 2);
      total++;
      if (timeout || obs_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rand%0d count got %0d want %0d timeout=%b", it, obs_q.size(), exp_q.size(), timeout);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        total++;
        if (obs_q[i] != exp_q[i]) begin
          bad++;
          $display("FAIL rand%0d beat %0d got meta=%h l=%b mv=%b d=%h k=%h want meta=%h l=%b mv=%b d=%h k=%h", it, i,
                   obs_q[i].meta, obs_q[i].last, obs_q[i].mvalid, obs_q[i].data, obs_q[i].keep,
                   exp_q[i].meta, exp_q[i].last, exp_q[i].mvalid, exp_q[i].data, exp_q[i].keep);
        end
      end
      total++;
      if (trunc_cyc_q.size() != model_trunc - t0) begin
        bad++; $display("FAIL rand%0d pulses got %0d want %0d", it, trunc_cyc_q.size(), model_trunc - t0);
      end
      for (int i = 0; i < trunc_cyc_q.size() && i < forced_cyc_q.size(); i++) begin
        total++;
        if (trunc_cyc_q[i] != forced_cyc_q[i] + 1) begin
          bad++; $display("FAIL rand%0d pulse_cycle got %0d want %0d", it, trunc_cyc_q[i], forced_cyc_q[i] + 1);
        end
      end
      total++;
      if (rdy_viol != 0) begin bad++; $display("FAIL rand%0d in_tready got %0d bad cycles want 0", it, rdy_viol); end
      $display("test_random iter %0d: %0d beats, %0d truncations", it, obs_q.size(), trunc_cyc_q.size());
    end
`ifdef P4_ROUTER_INGRESS_ARB_PKT_CNT_EN
    for (int p = 0; p < NP; p++) begin
      total++;
      if (pkt_cnt[p*32 +: 32] !== 32'(exp_cnt[p])) begin
        bad++; $display("FAIL pkt_cnt[%0d] got %0d want %0d", p, pkt_cnt[p*32 +: 32], exp_cnt[p]);
      end
    end
`endif
  endtask

  task automatic test_sreset_mid();
    add_pkt(9, 5);
    port_en = '1;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      drive_inputs(0);
      if (w >= 2) sreset = 1'b1;
      #1;
      if (w == 1) begin
        total++;
        if (!out_tvalid || user_metadata_out !== UMW'(9)) begin
          bad++; $display("FAIL sreset_pre got v=%b meta=%h want v=1 meta=0009", out_tvalid, user_metadata_out);
        end
      end
      if (w == 3) begin
        total++;
        if ({in_tready, out_tvalid, out_tlast, out_tdata, out_tkeep} !== '0) begin
          bad++; $display("FAIL sreset_out got rdy=%h v=%b l=%b d=%h want 0", in_tready, out_tvalid, out_tlast, out_tdata);
        end
        total++;
        if ({user_metadata_out, user_metadata_out_valid, truncate_event} !== '0) begin
          bad++; $display("FAIL sreset_meta got %h/%b trunc=%b want 0", user_metadata_out, user_metadata_out_valid, truncate_event);
        end
`ifdef P4_ROUTER_INGRESS_ARB_PKT_CNT_EN
        total++;
        if (pkt_cnt !== '0) begin bad++; $display("FAIL sreset_pkt_cnt got %h want 0", pkt_cnt); end
`endif
      end
      pop_sources();
    end
    // Source side is reset together with the arbiter.
    src_q[9].delete();
    @(negedge clk);
    drive_inputs(0);
    sreset = 1'b0;
    model_rr = 0;
    for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
    add_pkt(2, 1);
    run_traffic('1, 0);
    total++;
    if (timeout || obs_q.size() != 1 || obs_q.size() != exp_q.size() || obs_q[0] != exp_q[0]) begin
      bad++; $display("FAIL sreset_recover got %0d beats want %0d timeout=%b", obs_q.size(), exp_q.size(), timeout);
    end
    $display("test_sreset_mid done");
  endtask

  initial begin
    total = 0; bad = 0; model_trunc = 0; model_rr = 0; cyc = 0;
    sreset = 1'b1; port_en = '0; in_tvalid = '0; in_tlast = '0;
    in_tdata = '0; in_tkeep = '0; out_tready = 1'b0;
    test_reset();
    test_rr_order();
    test_back_to_back();
    test_truncate();
    test_backpressure();
    test_port_en();
    test_random();
    test_sreset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
